// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, imem request/response channel and decode-side
// instruction handshake. master = fetch unit, slave = environment (control unit, imem, decode).
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem read in flight and buffers {instr, pc} for decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed event counters.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_flushed
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_DISCARD
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_instr_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_d    [FIFO_DEPTH];
  logic                  req_fire;
  logic                  push;
  logic                  pop;

  // Space is checked at issue time, so a returning response always has a slot.
  assign bus.imem_req_valid = (state_q == ST_RUN) && (count_q < CNT_W'(FIFO_DEPTH)) &&
                              !bus.redirect && !rst;
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = (count_q != '0) && !rst;
  assign bus.instr          = fifo_instr_q[rd_ptr_q];
  assign bus.instr_pc       = fifo_pc_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    req_fire     = bus.imem_req_valid && bus.imem_req_ready;
    push         = 1'b0;
    pop          = 1'b0;

    if (bus.redirect) begin
      // Redirect wins: flush, drop any same-cycle push/pop, and mark an unanswered request stale.
      pc_d     = bus.redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (state_q != ST_RUN) begin
        state_d = bus.imem_rsp_valid ? ST_RUN : ST_DISCARD;
      end
    end else begin
      pop = bus.instr_valid && bus.instr_ready;
      case (state_q)
        ST_RUN: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_WIDTH'(4);
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            push    = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_DISCARD: begin
          if (bus.imem_rsp_valid) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase

      if (push) begin
        fifo_instr_d[wr_ptr_q] = bus.imem_rsp_data;
        fifo_pc_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q     <= req_pc_d;
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(push);
    perf_flushed_d = perf_flushed_q + 32'(bus.redirect);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model plus an imem responder with settable latency,
// checked every cycle, and directed scenarios pinned with literal expectations.
module tb_fetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  // Reference model: program counter, one-outstanding flag, stale flag, buffered entries.
  entry_t        m_q[$];
  logic [AW-1:0] m_pc     = '0;
  logic [AW-1:0] m_req_pc = '0;
  bit            m_out    = 1'b0;
  bit            m_stale  = 1'b0;
  int unsigned   m_fetched = 0;
  int unsigned   m_flushed = 0;

  // Memory responder state and observation logs
  int            mem_lat    = 1;
  int            mem_cnt    = 0;
  int            mem_budget = 1000000;
  logic [AW-1:0] mem_addr   = '0;
  logic [AW-1:0] log_addr[$];
  int            log_addr_cyc[$];
  entry_t        log_pop[$];
  int            first_valid = -1;
  int            cyc = 0;

  logic   pred_req;
  logic   pred_iv;
  entry_t e;

  always @(negedge clk) begin
    cyc++;
    pred_req = !rst && !bus.redirect && !m_out && (m_q.size() < DEPTH);
    pred_iv  = !rst && (m_q.size() > 0);

    check("imem_req_valid", bus.imem_req_valid, pred_req);
    if (pred_req) check("imem_addr", bus.imem_addr, m_pc);
    check("instr_valid", bus.instr_valid, pred_iv);
    if (pred_iv) begin
      check("instr", bus.instr, m_q[0].instr);
      check("instr_pc", bus.instr_pc, m_q[0].pc);
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_flushed", perf_flushed, m_flushed);
`endif

    if (!rst && !bus.redirect && bus.instr_valid && bus.instr_ready) begin
      e.instr = bus.instr;
      e.pc    = bus.instr_pc;
      log_pop.push_back(e);
    end
    if (!rst && bus.instr_valid && first_valid < 0) first_valid = cyc;

    bus.imem_rsp_valid = 1'b0;
    if (rst) begin
      mem_cnt = 0;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mem_addr);
      end
    end
    bus.imem_req_ready = (mem_budget > 0);
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      mem_cnt  = mem_lat;
      mem_addr = bus.imem_addr;
      mem_budget--;
      log_addr.push_back(bus.imem_addr);
      log_addr_cyc.push_back(cyc);
    end

    if (rst) begin
      m_pc = 32'h0;
      m_out = 1'b0;
      m_stale = 1'b0;
      m_q.delete();
      m_fetched = 0;
      m_flushed = 0;
    end else if (bus.redirect) begin
      m_q.delete();
      m_pc = bus.redirect_pc;
      m_flushed++;
      if (m_out && !bus.imem_rsp_valid) begin
        m_stale = 1'b1;
      end else begin
        m_out = 1'b0;
        m_stale = 1'b0;
      end
    end else begin
      if (pred_iv && bus.instr_ready) void'(m_q.pop_front());
      if (m_out && bus.imem_rsp_valid) begin
        if (!m_stale) begin
          e.instr = bus.imem_rsp_data;
          e.pc    = m_req_pc;
          m_q.push_back(e);
          m_fetched++;
        end
        m_out = 1'b0;
        m_stale = 1'b0;
      end else if (pred_req && bus.imem_req_ready) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_out    = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_addr_cyc.delete();
    log_pop.delete();
    first_valid = -1;
  endtask

  task automatic start_reset();
    rst = 1'b1;
    tick(2);
    clear_logs();
    rst = 1'b0;
  endtask

  initial begin
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_instr_valid", bus.instr_valid, 1'b0);

    // Streaming with 1-cycle memory
    tick(1);
    start_reset();
    tick(12);
    check("p1_nreq_ge3", log_addr.size() >= 3, 1'b1);
    check("p1_addr0", log_addr[0], 32'h0);
    check("p1_addr1", log_addr[1], 32'h4);
    check("p1_addr2", log_addr[2], 32'h8);
    check("p1_req_spacing", log_addr_cyc[1] - log_addr_cyc[0], 2);
    check("p1_first_valid_lat", first_valid - log_addr_cyc[0], 2);
    check("p1_npop_ge3", log_pop.size() >= 3, 1'b1);
    check("p1_pop0_pc", log_pop[0].pc, 32'h0);
    check("p1_pop0_instr", log_pop[0].instr, 32'hDEADBEEF);
    check("p1_pop1_pc", log_pop[1].pc, 32'h4);
    check("p1_pop1_instr", log_pop[1].instr, 32'hDEADBEEB);
    check("p1_pop2_pc", log_pop[2].pc, 32'h8);
    check("p1_pop2_instr", log_pop[2].instr, 32'hDEADBEE7);

    // Backpressure: buffer fills to two entries and holds
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    tick(2);
    clear_logs();
    rst = 1'b0;
    tick(11);
    @(negedge clk);
    check("p2_req_stalled", bus.imem_req_valid, 1'b0);
    check("p2_nreq", log_addr.size(), 2);
    check("p2_hold_valid", bus.instr_valid, 1'b1);
    check("p2_hold_pc", bus.instr_pc, 32'h0);
    check("p2_hold_instr", bus.instr, 32'hDEADBEEF);
    tick(1);
    log_pop.delete();
    bus.instr_ready = 1'b1;
    tick(10);
    check("p2_drain0_pc", log_pop[0].pc, 32'h0);
    check("p2_drain1_pc", log_pop[1].pc, 32'h4);
    check("p2_drain1_instr", log_pop[1].instr, 32'hDEADBEEB);
    check("p2_drain2_pc", log_pop[2].pc, 32'h8);

    // Redirect while waiting on a 3-cycle response
    rst = 1'b1;
    mem_lat = 3;
    tick(2);
    clear_logs();
    rst = 1'b0;
    tick(1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    tick(1);
    bus.redirect = 1'b0;
    tick(14);
    check("p3_addr0", log_addr[0], 32'h0);
    check("p3_addr1", log_addr[1], 32'h40);
    check("p3_redirect_gap", log_addr_cyc[1] - log_addr_cyc[0], 4);
    check("p3_pop0_pc", log_pop[0].pc, 32'h40);
    check("p3_pop0_instr", log_pop[0].instr, 32'hDEADBEAF);

    // Redirect coinciding with a response and a pop
    rst = 1'b1;
    mem_lat = 1;
    bus.instr_ready = 1'b0;
    tick(2);
    clear_logs();
    rst = 1'b0;
    tick(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("p4_pop_present", bus.instr_valid, 1'b1);
    tick(1);
    bus.redirect = 1'b0;
    log_pop.delete();
    @(negedge clk);
    check("p4_flushed", bus.instr_valid, 1'b0);
    check("p4_req_now", bus.imem_req_valid, 1'b1);
    check("p4_req_addr", bus.imem_addr, 32'h100);
    tick(6);
    check("p4_pop0_pc", log_pop[0].pc, 32'h100);
    check("p4_pop0_instr", log_pop[0].instr, 32'hDEADBFEF);

    // PC wrap at the top of the address space, then an unaligned target
    start_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    bus.redirect = 1'b0;
    tick(8);
    check("p5_addr0", log_addr[0], 32'hFFFF_FFFC);
    check("p5_addr_wrap", log_addr[1], 32'h0);
    check("p5_pop0_pc", log_pop[0].pc, 32'hFFFF_FFFC);
    check("p5_pop0_instr", log_pop[0].instr, 32'h2152_4113);
    check("p5_pop1_pc", log_pop[1].pc, 32'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h102;
    clear_logs();
    tick(1);
    bus.redirect = 1'b0;
    tick(10);
    check("p5_unaligned0", log_addr[0], 32'h102);
    check("p5_unaligned1", log_addr[1], 32'h106);
    check("p5_unaligned_pop", log_pop[0].pc, 32'h102);

`ifdef FETCH_PERF_CNT_EN
    // Five fetches and two redirect cycles
    rst = 1'b1;
    tick(2);
    clear_logs();
    mem_budget = 5;
    rst = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    tick(1);
    bus.redirect_pc = 32'h300;
    tick(1);
    bus.redirect = 1'b0;
    tick(20);
    @(negedge clk);
    check("perf_fetched_5", perf_fetched, 32'd5);
    check("perf_flushed_2", perf_flushed, 32'd2);
    tick(1);
    mem_budget = 1000000;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("perf_fetched_rst", perf_fetched, 32'd0);
    check("perf_flushed_rst", perf_flushed, 32'd0);
    tick(4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
